vtree_filler: RTL and testbench

Front-end feeder for the virtual merge sorter tree. Holds a small per-way queue of P-record input blocks (one block = 1<<P_LOG records) and round-robin arbitrates among ways whose tree-side empty flag is set. It issues at most one block per cycle on the tree's `din`/`dinen`/`din_idx` interface. It sits directly upstream of the tree and downstream of the per-way record sources (memory readers or test generators).

---
 rtl/vtree_filler_pkg.sv | 21 ++
 rtl/vtree_fifo2.sv | 71 +++++++
 rtl/vtree_filler.sv | 113 +++++++++++
 tb/tb_vtree_filler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vtree_filler_pkg.sv
// Shared defaults and width helpers for the virtual merge tree front end.
// The tree, the filler and the bench all take their default geometry from here.
package vtree_filler_pkg;

   localparam int VT_W_LOG = 5;
   localparam int VT_P_LOG = 3;
   localparam int VT_DATW  = 64;
   localparam int VT_HOLD  = 2;

   // Width of one block of (1<<p_log) records.
   function automatic int blk_w(input int datw, input int p_log);
      return datw << p_log;
   endfunction

   // Hold counter width: clog2(hold+1), never narrower than one bit.
   function automatic int hold_w(input int hold);
      if (hold <= 1) return 1;
      return $clog2(hold + 1);
   endfunction

endpackage

// File: rtl/vtree_fifo2.sv
// Two-entry block FIFO for one way of the filler.
// Enqueue while full is dropped; enqueue plus dequeue at occupancy 1 replaces the head.
module vtree_fifo2 #(
   parameter int BW = 512
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          enq,
   input  logic          deq,
   input  logic [BW-1:0] din,
   output logic [BW-1:0] dot,
   output logic          emp,
   output logic          full
);

   logic [BW-1:0] head_q, head_d;
   logic [BW-1:0] tail_q, tail_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          do_enq;
   logic          do_deq;

   always_comb begin
      do_enq = enq & (cnt_q != 2'd2);
      do_deq = deq & (cnt_q != 2'd0);
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case (cnt_q)
         2'd0: begin
            if (do_enq) begin
               head_d = din;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (do_enq && do_deq) begin
               head_d = din;
            end else if (do_enq) begin
               tail_d = din;
               cnt_d  = 2'd2;
            end else if (do_deq) begin
               cnt_d  = 2'd0;
            end
         end
         default: begin
            // Full: any enqueue was already suppressed above.
            if (do_deq) begin
               head_d = tail_q;
               cnt_d  = 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dot  = head_q;
   assign emp  = (cnt_q == 2'd0);
   assign full = (cnt_q == 2'd2);

endmodule

// File: rtl/vtree_filler.sv
// Feeds blocks from per-way queues into the merge tree, one per cycle,
// round-robin among ways the tree reports empty and that are not in hold-off.
module vtree_filler
   import vtree_filler_pkg::*;
#(
   parameter int W_LOG = VT_W_LOG,
   parameter int P_LOG = VT_P_LOG,
   parameter int DATW  = VT_DATW,
   parameter int HOLD  = VT_HOLD
) (
   input  logic                                  CLK,
   input  logic                                  RST,
   input  logic [((DATW<<P_LOG)<<W_LOG)-1:0]     IN_DATA,
   input  logic [(1<<W_LOG)-1:0]                 IN_ENQ,
   output logic [(1<<W_LOG)-1:0]                 IN_FULL,
   input  logic [(1<<W_LOG)-1:0]                 TREE_EMP,
   output logic [(DATW<<P_LOG)-1:0]              DOT,
   output logic                                  DOTEN,
   output logic [W_LOG-1:0]                      DOT_IDX
);

   localparam int W  = 1 << W_LOG;
   localparam int BW = blk_w(DATW, P_LOG);
   localparam int HW = hold_w(HOLD);
   localparam logic [HW-1:0] HOLD_V = HW'(HOLD);

   logic [W-1:0]     emp;
   logic [W-1:0]     full;
   logic [W-1:0]     elig;
   logic [W-1:0]     gnt_vec;
   logic [BW-1:0]    head [W];
   logic [HW-1:0]    hold_q [W];
   logic [HW-1:0]    hold_d [W];

   logic             gnt_vld;
   logic [W_LOG-1:0] gnt_idx;
   logic [W_LOG-1:0] scan_idx;

   logic [BW-1:0]    dot_q, dot_d;
   logic             doten_q, doten_d;
   logic [W_LOG-1:0] dot_idx_q, dot_idx_d;
   logic [W_LOG-1:0] ptr_q, ptr_d;

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_way
         vtree_fifo2 #(.BW(BW)) u_fifo (
            .CLK  (CLK),
            .RST  (RST),
            .enq  (IN_ENQ[gi]),
            .deq  (gnt_vec[gi]),
            .din  (IN_DATA[gi*BW +: BW]),
            .dot  (head[gi]),
            .emp  (emp[gi]),
            .full (full[gi])
         );
         assign elig[gi] = ~emp[gi] & TREE_EMP[gi] & (hold_q[gi] == '0);
      end
   endgenerate

   // Round-robin: first eligible way at or after ptr, wrapping at W_LOG bits.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int k = 0; k < W; k++) begin
         scan_idx = ptr_q + W_LOG'(k);
         if (!gnt_vld && elig[scan_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = scan_idx;
         end
      end
      gnt_vec = '0;
      if (gnt_vld) gnt_vec[gnt_idx] = 1'b1;
   end

   always_comb begin
      dot_d     = dot_q;
      doten_d   = gnt_vld;
      dot_idx_d = dot_idx_q;
      ptr_d     = ptr_q;
      if (gnt_vld) begin
         dot_d     = head[gnt_idx];
         dot_idx_d = gnt_idx;
         ptr_d     = gnt_idx + W_LOG'(1);
      end
      for (int i = 0; i < W; i++) begin
         hold_d[i] = (hold_q[i] != '0) ? hold_q[i] - HW'(1) : '0;
         if (gnt_vec[i]) hold_d[i] = HOLD_V;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dot_q     <= '0;
         doten_q   <= 1'b0;
         dot_idx_q <= '0;
         ptr_q     <= '0;
         for (int i = 0; i < W; i++) hold_q[i] <= '0;
      end else begin
         dot_q     <= dot_d;
         doten_q   <= doten_d;
         dot_idx_q <= dot_idx_d;
         ptr_q     <= ptr_d;
         for (int i = 0; i < W; i++) hold_q[i] <= hold_d[i];
      end
   end

   assign DOT     = dot_q;
   assign DOTEN   = doten_q;
   assign DOT_IDX = dot_idx_q;
   assign IN_FULL = full;

endmodule

// File: tb/tb_vtree_filler.sv
// Directed bench for vtree_filler at default geometry (32 ways, 8x64-bit records, hold 2).
module tb_vtree_filler;
   import vtree_filler_pkg::*;

   localparam int W_LOG = VT_W_LOG;
   localparam int W     = 1 << W_LOG;
   localparam int BW    = VT_DATW << VT_P_LOG;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic [BW*W-1:0]      IN_DATA;
   logic [W-1:0]         IN_ENQ;
   logic [W-1:0]         IN_FULL;
   logic [W-1:0]         TREE_EMP;
   logic [BW-1:0]        DOT;
   logic                 DOTEN;
   logic [W_LOG-1:0]     DOT_IDX;

   int total = 0;
   int bad   = 0;

   vtree_filler dut (
      .CLK      (CLK),
      .RST      (RST),
      .IN_DATA  (IN_DATA),
      .IN_ENQ   (IN_ENQ),
      .IN_FULL  (IN_FULL),
      .TREE_EMP (TREE_EMP),
      .DOT      (DOT),
      .DOTEN    (DOTEN),
      .DOT_IDX  (DOT_IDX)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int way;
      int tag;
      int exp_idx;
   } vec_t;

   // Block pattern: every record tagged with way, tag and record number.
   function automatic logic [BW-1:0] mk(input int way, input int tag);
      logic [BW-1:0] b;
      for (int r = 0; r < (1 << VT_P_LOG); r++)
         b[r*64 +: 64] = {16'hA5A5, 8'(way), 8'(tag), 8'(r), 24'h5A5A5A};
      return b;
   endfunction

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic put(input int way, input int tag);
      IN_DATA[way*BW +: BW] = mk(way, tag);
      IN_ENQ[way] = 1'b1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      IN_ENQ = '0;
      step();
      step();
      RST = 1'b0;
   endtask

   vec_t vecs[4];
   logic [BW-1:0] got[$];

   initial begin
      vecs[0] = '{way: 3,  tag: 1, exp_idx: 3};
      vecs[1] = '{way: 0,  tag: 2, exp_idx: 0};
      vecs[2] = '{way: 31, tag: 3, exp_idx: 31};
      vecs[3] = '{way: 17, tag: 4, exp_idx: 17};

      IN_DATA  = '0;
      IN_ENQ   = '0;
      TREE_EMP = '0;
      do_reset();
      chk("reset_doten", BW'(DOTEN), BW'(0));
      chk("reset_dot", DOT, '0);
      chk("reset_idx", BW'(DOT_IDX), BW'(0));
      chk("reset_full", BW'(IN_FULL), BW'(0));

      // Single-way latency, table driven
      TREE_EMP = '1;
      for (int v = 0; v < 4; v++) begin
         put(vecs[v].way, vecs[v].tag);
         step();
         IN_ENQ = '0;
         chk($sformatf("single%0d_pre", v), BW'(DOTEN), BW'(0));
         step();
         chk($sformatf("single%0d_en", v), BW'(DOTEN), BW'(1));
         chk($sformatf("single%0d_idx", v), BW'(DOT_IDX), BW'(vecs[v].exp_idx));
         chk($sformatf("single%0d_dot", v), DOT, mk(vecs[v].way, vecs[v].tag));
         step();
         chk($sformatf("single%0d_post", v), BW'(DOTEN), BW'(0));
      end

      // Overflow on way 2
      TREE_EMP = '0;
      put(2, 10); step();
      put(2, 11); step();
      chk("ovf_full_after2", BW'(IN_FULL[2]), BW'(1));
      put(2, 12); step();
      IN_ENQ = '0;
      chk("ovf_full_after3", BW'(IN_FULL[2]), BW'(1));
      TREE_EMP[2] = 1'b1;
      got.delete();
      for (int c = 0; c < 10; c++) begin
         step();
         if (DOTEN) got.push_back(DOT);
      end
      chk("ovf_count", BW'(got.size()), BW'(2));
      if (got.size() >= 2) begin
         chk("ovf_first", got[0], mk(2, 10));
         chk("ovf_second", got[1], mk(2, 11));
      end

      // Empty-flag gating on way 5
      TREE_EMP = '0;
      put(5, 20); step();
      IN_ENQ = '0;
      for (int c = 0; c < 20; c++) begin
         step();
         chk($sformatf("gate_idle%0d", c), BW'(DOTEN), BW'(0));
      end
      TREE_EMP[5] = 1'b1;
      step();
      chk("gate_en", BW'(DOTEN), BW'(1));
      chk("gate_idx", BW'(DOT_IDX), BW'(5));
      chk("gate_dot", DOT, mk(5, 20));

      // Hold-off on way 7
      TREE_EMP = '0;
      put(7, 30); step();
      put(7, 31); step();
      IN_ENQ = '0;
      TREE_EMP = '1;
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("hold_en%0d", c), BW'(DOTEN), BW'((c == 0 || c == 3) ? 1 : 0));
         if (c == 0) chk("hold_dot0", DOT, mk(7, 30));
         if (c == 3) chk("hold_dot1", DOT, mk(7, 31));
      end

      // Full round-robin from a fresh pointer
      do_reset();
      TREE_EMP = '0;
      for (int i = 0; i < W; i++) put(i, 40);
      step();
      for (int i = 0; i < W; i++) put(i, 41);
      step();
      IN_ENQ = '0;
      chk("rr_full", BW'(IN_FULL), {{(BW-W){1'b0}}, {W{1'b1}}});
      TREE_EMP = '1;
      for (int k = 0; k < 2*W; k++) begin
         step();
         chk($sformatf("rr%0d_en", k), BW'(DOTEN), BW'(1));
         chk($sformatf("rr%0d_idx", k), BW'(DOT_IDX), BW'(k % W));
         chk($sformatf("rr%0d_dot", k), DOT, mk(k % W, 40 + k / W));
      end
      step();
      chk("rr_drained", BW'(DOTEN), BW'(0));

      // Reset in the middle of a round-robin drain
      TREE_EMP = '0;
      for (int i = 0; i < W; i++) put(i, 50);
      step();
      for (int i = 0; i < W; i++) put(i, 51);
      step();
      IN_ENQ = '0;
      TREE_EMP = '1;
      for (int k = 0; k < 10; k++) step();
      chk("mid_running", BW'(DOTEN), BW'(1));
      RST = 1'b1;
      step();
      chk("mid_rst_doten", BW'(DOTEN), BW'(0));
      chk("mid_rst_full", BW'(IN_FULL), BW'(0));
      RST = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("mid_nostale%0d", c), BW'(DOTEN), BW'(0));
      end
      // Pointer at 0 picks way 2 before way 20; a stale pointer would not.
      put(2, 60);
      put(20, 61);
      step();
      IN_ENQ = '0;
      step();
      chk("mid_first_idx", BW'(DOT_IDX), BW'(2));
      chk("mid_first_dot", DOT, mk(2, 60));
      step();
      chk("mid_second_idx", BW'(DOT_IDX), BW'(20));
      chk("mid_second_dot", DOT, mk(20, 61));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
